bus_slave_port: RTL

//  Slave-side serial bus endpoint. It is the downstream consumer of the bus master's serial frames.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/serial_shift_in.sv | 25 ++
 rtl/bus_slave_port.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: field widths, slave FSM encoding, burst length.
package bus_pkg;

  localparam int ADDR_BITS  = 14;
  localparam int DATA_BITS  = 8;
  localparam int BURST_BITS = 3;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WR,
    RD_REQ,
    RD_WAIT,
    RD_TX,
    BST_WAIT,
    BST_DATA,
    DRAIN
  } state_t;

  function automatic logic [9:0] burst_len(
    input logic [BURST_BITS-1:0] code
  );
    return 10'd4 << code;
  endfunction

endpackage

// File: rtl/serial_shift_in.sv
// MSB-first serial deserialiser; q already includes the bit on bit_in,
// so the full word is usable on the same edge that samples its last bit.
module serial_shift_in #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] q
);

  logic [W-2:0] r;

  assign q = {r, bit_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      r <= '0;
    end else if (shift_en) begin
      r <= q[W-2:0];
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// Slave endpoint of the serial bus: frame decode, single/burst writes,
// single reads serialised back to the master.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID = 2'd0,
  parameter int         MEM_AW   = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              write_en,
  input  logic              addr_rx,
  input  logic              data_rx,
  input  logic              burst_rx,
  output logic              slave_ready,
  output logic              slave_valid,
  output logic              data_tx,
  output logic              slave_busy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic                  need_low;
  logic [BURST_BITS-1:0] code_q;
  logic [9:0]            beat;
  logic [DATA_BITS-1:0]  rd_sh;

  logic [ADDR_BITS-1:0]  addr_full;
  logic [DATA_BITS-1:0]  data_full;
  logic [BURST_BITS-1:0] code_full;
  logic                  in_addr;
  logic                  a_en;
  logic                  d_en;
  logic                  b_en;

  assign in_addr = (state == ADDR);
  assign a_en    = in_addr;
  assign d_en    = (in_addr && cnt >= 4'd6) || (state == BST_DATA);
  assign b_en    = in_addr && cnt >= 4'd11;

  serial_shift_in #(.W(ADDR_BITS)) u_addr (
    .clock    (clock),
    .reset    (reset),
    .shift_en (a_en),
    .bit_in   (addr_rx),
    .q        (addr_full)
  );

  serial_shift_in #(.W(DATA_BITS)) u_data (
    .clock    (clock),
    .reset    (reset),
    .shift_en (d_en),
    .bit_in   (data_rx),
    .q        (data_full)
  );

  serial_shift_in #(.W(BURST_BITS)) u_burst (
    .clock    (clock),
    .reset    (reset),
    .shift_en (b_en),
    .bit_in   (burst_rx),
    .q        (code_full)
  );

  assign slave_busy = (state != IDLE);

  // need_low blocks a new frame until valid has been seen low
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      need_low    <= 1'b0;
      code_q      <= '0;
      beat        <= '0;
      rd_sh       <= '0;
      slave_ready <= 1'b0;
      slave_valid <= 1'b0;
      data_tx     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      slave_valid <= 1'b0;
      data_tx     <= 1'b0;
      if (!valid) need_low <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid && !need_low) begin
            state <= ADDR;
            cnt   <= '0;
          end
        end
        ADDR: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd0) we_q <= write_en;
          if (cnt != 4'd13) begin
            if (!valid) state <= IDLE;
          end else begin
            code_q   <= code_full;
            beat     <= 10'd1;
            mem_addr <= addr_full[MEM_AW-1:0];
            if (addr_full[13:12] != SLAVE_ID) begin
              state <= DRAIN;
            end else if (we_q) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= data_full;
            end else begin
              state  <= RD_REQ;
              mem_re <= 1'b1;
            end
          end
        end
        WR: begin
          if (code_q != '0 && beat != burst_len(code_q)) begin
            state       <= BST_WAIT;
            slave_ready <= 1'b1;
          end else begin
            state    <= IDLE;
            need_low <= valid;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          rd_sh       <= mem_rdata;
          slave_valid <= 1'b1;
          cnt         <= '0;
          state       <= RD_TX;
        end
        RD_TX: begin
          if (cnt == 4'd8) begin
            state    <= IDLE;
            need_low <= valid;
          end else begin
            data_tx <= rd_sh[7];
            rd_sh   <= {rd_sh[6:0], 1'b0};
            cnt     <= cnt + 4'd1;
          end
        end
        BST_WAIT: begin
          if (valid) begin
            state       <= BST_DATA;
            slave_ready <= 1'b0;
            cnt         <= '0;
          end
        end
        BST_DATA: begin
          if (!valid) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              mem_we    <= 1'b1;
              mem_addr  <= mem_addr + ADDR_ONE;
              mem_wdata <= data_full;
              beat      <= beat + 10'd1;
              state     <= WR;
            end
          end
        end
        DRAIN: begin
          if (!valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
